// File: rtl/pyr_down2x_axis.sv
// 2x2 box-average decimator for 8-bit grey frames on AXI-Stream.
// Even rows park horizontal pair sums in a line buffer. Odd rows combine
// them with the current pair and emit one rounded average per 2x2 block.
module pyr_down2x_axis #(
  parameter int unsigned MAX_W = 640,
  parameter int unsigned MAX_H = 428
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cfg_w,
  input  logic [15:0] cfg_h,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [15:0] out_w,
  output logic [15:0] out_h,
  output logic        frame_done,
  output logic        err_tlast,
  output logic        err_cfg
);

  localparam int unsigned LB_DEPTH = MAX_W / 2;
  localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state;
  logic [15:0] w_q, h_q, x, y;
  logic [7:0]  prev;
  logic [8:0]  lbuf [LB_DEPTH];

  logic             accept, sof, cfg_ok, start, proc, x_last, y_last, store, emit;
  logic [15:0]      cur_x, cur_y, cur_w, cur_h;
  logic [LB_AW-1:0] lb_idx;
  logic [8:0]       pair;
  logic [9:0]       sum;
  logic [7:0]       avg;

  // One-deep output register: accept input whenever that register can take a beat.
  assign s_axis_tready = rst_n && (!m_axis_tvalid || m_axis_tready);

  // Beat classification and datapath. A legal SOF beat is processed as pixel
  // (0,0) of the new frame, so the current-position view switches to cfg values.
  always_comb begin
    accept = s_axis_tvalid && s_axis_tready;
    sof    = accept && s_axis_tuser;
    cfg_ok = (cfg_w <= 16'(MAX_W)) && (cfg_h <= 16'(MAX_H)) &&
             (cfg_w >= 16'd2) && (cfg_h >= 16'd2);
    start  = sof && cfg_ok;
    proc   = start || (accept && !s_axis_tuser && (state == ACTIVE));
    cur_x  = start ? '0 : x;
    cur_y  = start ? '0 : y;
    cur_w  = start ? cfg_w : w_q;
    cur_h  = start ? cfg_h : h_q;
    x_last = (cur_x == cur_w - 16'd1);
    y_last = (cur_y == cur_h - 16'd1);
    lb_idx = LB_AW'(cur_x >> 1);
    pair   = 9'(prev) + 9'(s_axis_tdata);
    sum    = 10'(lbuf[lb_idx]) + 10'(pair);
    avg    = 8'((sum + 10'd2) >> 2);
    store  = proc && !cur_y[0] && cur_x[0];
    emit   = proc &&  cur_y[0] && cur_x[0];
  end

  // Line buffer of even-row pair sums; contents need no reset.
  always_ff @(posedge clk) begin
    if (store) lbuf[lb_idx] <= pair;
  end

  // Frame FSM, position counters, status flags and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      w_q           <= '0;
      h_q           <= '0;
      x             <= '0;
      y             <= '0;
      prev          <= '0;
      out_w         <= '0;
      out_h         <= '0;
      frame_done    <= 1'b0;
      err_tlast     <= 1'b0;
      err_cfg       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (emit) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= avg;
        m_axis_tuser  <= (cur_x == 16'd1) && (cur_y == 16'd1);
        m_axis_tlast  <= (cur_x >> 1) == ((cur_w >> 1) - 16'd1);
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end

      // Any SOF aborts the current frame; an illegal one parks the FSM in IDLE.
      if (sof) begin
        err_tlast <= 1'b0;
        if (cfg_ok) begin
          err_cfg <= 1'b0;
          w_q     <= cfg_w;
          h_q     <= cfg_h;
          out_w   <= cfg_w >> 1;
          out_h   <= cfg_h >> 1;
        end else begin
          err_cfg <= 1'b1;
          state   <= IDLE;
        end
      end

      // The tlast check below follows the SOF clear so it still flags the SOF beat.
      if (proc) begin
        prev <= s_axis_tdata;
        if (s_axis_tlast != x_last) err_tlast <= 1'b1;
        if (x_last) begin
          x <= '0;
          if (y_last) begin
            y          <= '0;
            state      <= IDLE;
            frame_done <= 1'b1;
          end else begin
            y     <= cur_y + 16'd1;
            state <= ACTIVE;
          end
        end else begin
          x     <= cur_x + 16'd1;
          y     <= cur_y;
          state <= ACTIVE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pyr_down2x_axis.sv
// Directed bench for pyr_down2x_axis: hand-computed small frames, a random
// frame against a 2x2 average model, stalls, abort, bad config and reset.
module tb_pyr_down2x_axis;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_w, cfg_h;
  logic [7:0]  s_data;
  logic        s_valid, s_ready, s_last, s_user;
  logic [7:0]  m_data;
  logic        m_valid, m_ready, m_last, m_user;
  logic [15:0] out_w, out_h;
  logic        frame_done, err_tlast, err_cfg;

  int nvec = 0;
  int nerr = 0;
  int fd_cnt = 0;
  logic stall_en = 1'b0;

  logic [7:0] img [16][16];
  logic [7:0] qd [$];
  logic       qu [$];
  logic       ql [$];

  logic       stall_prev = 1'b0;
  logic [7:0] pd;
  logic       pu, pl;

  always #5 clk = ~clk;

  pyr_down2x_axis #(.MAX_W(640), .MAX_H(428)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_axis_tlast(m_last), .m_axis_tuser(m_user),
    .out_w(out_w), .out_h(out_h), .frame_done(frame_done),
    .err_tlast(err_tlast), .err_cfg(err_cfg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (rst_n && stall_prev) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, pd);
      chk("hold_user", m_user, pu);
      chk("hold_last", m_last, pl);
    end
    stall_prev = rst_n && m_valid && !m_ready;
    pd = m_data; pu = m_user; pl = m_last;
    if (rst_n && m_valid && m_ready) begin
      qd.push_back(m_data); qu.push_back(m_user); ql.push_back(m_last);
    end
    if (frame_done) fd_cnt++;
  end

  // Random downstream back-pressure, about 30% not ready.
  always @(posedge clk) begin
    if (stall_en) begin
      #1 m_ready = ($urandom_range(0, 9) >= 3);
    end
  end

  task automatic send(input logic [7:0] d, input logic u, input logic l);
    logic acc = 1'b0;
    s_data = d; s_user = u; s_last = l; s_valid = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      if (s_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_user = 1'b0; s_last = 1'b0;
    chk("accept", acc, 1);
  endtask

  task automatic send_frame(input int w, input int h, input bit bad_first, input int limit);
    int n = 0;
    cfg_w = 16'(w); cfg_h = 16'(h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (n < limit) begin
          send(img[r][c], (r == 0 && c == 0), (c == w - 1) ^ (bad_first && r == 0 && c == 0));
          n++;
        end
  endtask

  task automatic settle();
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    qd.delete(); qu.delete(); ql.delete(); fd_cnt = 0;
  endtask

  task automatic check_beat(input string tag, input logic [7:0] d, input logic u, input logic l);
    logic [7:0] od = 8'hxx;
    logic ou = 1'bx, ol = 1'bx;
    if (qd.size() > 0) begin
      od = qd.pop_front(); ou = qu.pop_front(); ol = ql.pop_front();
    end
    chk({tag, "_data"}, od, d);
    chk({tag, "_user"}, ou, u);
    chk({tag, "_last"}, ol, l);
  endtask

  // Reference: rounded mean of each 2x2 block of img.
  task automatic check_model(input string tag, input int w, input int h);
    int ow = w / 2;
    int oh = h / 2;
    int s;
    chk({tag, "_count"}, qd.size(), ow * oh);
    for (int r = 0; r < oh; r++)
      for (int c = 0; c < ow; c++) begin
        s = img[2*r][2*c] + img[2*r][2*c+1] + img[2*r+1][2*c] + img[2*r+1][2*c+1];
        check_beat(tag, 8'((s + 2) / 4), (r == 0 && c == 0), (c == ow - 1));
      end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) img[r][c] = v;
  endtask

  task automatic set_row(input int r, input logic [7:0] a, b, c, d);
    img[r][0] = a; img[r][1] = b; img[r][2] = c; img[r][3] = d;
  endtask

  task automatic load_4x4();
    set_row(0, 0, 4, 8, 12);
    set_row(1, 2, 6, 10, 14);
    set_row(2, 1, 1, 1, 1);
    set_row(3, 3, 3, 3, 5);
  endtask

  initial begin
    rst_n = 1'b0; cfg_w = '0; cfg_h = '0;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_user = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", s_ready, 0);
    chk("rst_valid", m_valid, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_w", out_w, 0);
    chk("rst_out_h", out_h, 0);
    chk("rst_err_cfg", err_cfg, 0);
    chk("rst_err_tlast", err_tlast, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_tdata", m_data, 0);
    clear_q();

    // 4x4 directed frame
    load_4x4();
    send_frame(4, 4, 0, 1000);
    settle();
    chk("f4_count", qd.size(), 4);
    check_beat("f4_b0", 3, 1, 0);
    check_beat("f4_b1", 11, 0, 1);
    check_beat("f4_b2", 2, 0, 0);
    check_beat("f4_b3", 3, 0, 1);
    chk("f4_out_w", out_w, 2);
    chk("f4_out_h", out_h, 2);
    chk("f4_done", fd_cnt, 1);
    chk("f4_err_tlast", err_tlast, 0);
    clear_q();

    // 5x3 of 200: odd column and odd row dropped
    fill(200);
    send_frame(5, 3, 0, 1000);
    settle();
    chk("f5_count", qd.size(), 2);
    check_beat("f5_b0", 200, 1, 0);
    check_beat("f5_b1", 200, 0, 1);
    chk("f5_out_w", out_w, 2);
    chk("f5_out_h", out_h, 1);
    chk("f5_done", fd_cnt, 1);
    clear_q();

    // random 16x6 frame, free-running then with back-pressure
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) img[r][c] = 8'($urandom);
    img[0][0] = 255; img[0][1] = 255; img[1][0] = 255; img[1][1] = 255;
    send_frame(16, 6, 0, 1000);
    settle();
    check_model("rnd", 16, 6);
    chk("rnd_done", fd_cnt, 1);
    chk("rnd_out_w", out_w, 8);
    clear_q();
    stall_en = 1'b1;
    send_frame(16, 6, 0, 1000);
    settle();
    stall_en = 1'b0;
    @(posedge clk); #2;
    m_ready = 1'b1;
    settle();
    check_model("stall", 16, 6);
    chk("stall_done", fd_cnt, 1);
    clear_q();

    // 6x4 aborted after 9 pixels by a 4x2 SOF
    fill(10);
    send_frame(6, 4, 0, 9);
    set_row(0, 10, 20, 30, 40);
    set_row(1, 50, 60, 70, 80);
    send_frame(4, 2, 0, 1000);
    settle();
    chk("abort_count", qd.size(), 3);
    check_beat("abort_old", 10, 1, 0);
    check_beat("abort_n0", 35, 1, 0);
    check_beat("abort_n1", 55, 0, 1);
    chk("abort_done", fd_cnt, 1);
    clear_q();

    // illegal width, then legal 4x4 whose SOF beat carries a wrong tlast
    cfg_w = 16'd700; cfg_h = 16'd4;
    send(8'd9, 1, 0);
    send(8'd9, 0, 0);
    settle();
    chk("cfg_err", err_cfg, 1);
    chk("cfg_no_out", qd.size(), 0);
    load_4x4();
    send_frame(4, 4, 1, 1000);
    settle();
    chk("cfg_cleared", err_cfg, 0);
    chk("tlast_err", err_tlast, 1);
    chk("cfg_count", qd.size(), 4);
    check_beat("cfg_b0", 3, 1, 0);
    check_beat("cfg_b1", 11, 0, 1);
    check_beat("cfg_b2", 2, 0, 0);
    check_beat("cfg_b3", 3, 0, 1);
    clear_q();

    // reset mid-frame with a pending output beat
    m_ready = 1'b0;
    send_frame(4, 4, 0, 6);
    chk("pend_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_data", m_data, 0);
    chk("arst_user", m_user, 0);
    chk("arst_last", m_last, 0);
    chk("arst_out_w", out_w, 0);
    chk("arst_err_tlast", err_tlast, 0);
    chk("arst_ready", s_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    clear_q();
    send_frame(4, 4, 0, 1000);
    settle();
    check_model("post_rst", 4, 4);
    chk("post_rst_done", fd_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
